// File: rtl/display_pkg.sv
// Shared constants, glyph table, BCD sizing helper and converter state type
// for the multiplexed seven-segment display driver.
package display_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Active-low {dp,g,f,e,d,c,b,a}; entries 10-15 are the hex letters A-F
    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } conv_state_t;

    // ceil(data_w*log10(2) + 1), using log10(2) ~= 0.30103 in fixed point
    function automatic int bcd_nibbles(input int data_w);
        return (data_w * 30103 + 100000 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// Under DISPLAY_HEX_EN a hex request bypasses the shift phase and latches N's nibbles.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef DISPLAY_HEX_EN
    input  logic                 hex,
    output logic                 value_hex,
`endif
    input  logic [DATA_W-1:0]    bin,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_W-1:0]    value,
    output logic [4*NIBBLES-1:0] bcd
);

    localparam int BCD_W = 4 * NIBBLES;
    localparam int CW    = $clog2(DATA_W + 1);

    conv_state_t         state_q, state_d;
    logic [DATA_W-1:0]   sreg_q, sreg_d;
    logic [DATA_W-1:0]   value_q, value_d;
    logic [BCD_W-1:0]    acc_q, acc_d;
    logic [BCD_W-1:0]    adj;
    logic [CW-1:0]       cnt_q, cnt_d;
`ifdef DISPLAY_HEX_EN
    logic                hex_q, hex_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            value_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef DISPLAY_HEX_EN
            hex_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            value_q <= value_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`ifdef DISPLAY_HEX_EN
            hex_q   <= hex_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        value_d = value_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        adj     = acc_q;
`ifdef DISPLAY_HEX_EN
        hex_d   = hex_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    value_d = bin;
                    sreg_d  = bin;
                    acc_d   = '0;
                    cnt_d   = CW'(DATA_W);
                    state_d = SHIFT;
`ifdef DISPLAY_HEX_EN
                    hex_d   = hex;
                    if (hex) begin
                        acc_d   = BCD_W'(bin);
                        state_d = LATCH;
                    end
`endif
                end
            end
            SHIFT: begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (adj[4*i +: 4] >= 4'd5) begin
                        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
                    end
                end
                acc_d  = {adj[BCD_W-2:0], sreg_q[DATA_W-1]};
                sreg_d = sreg_q << 1;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = LATCH;
                end
            end
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == LATCH);
    assign value = value_q;
    assign bcd   = acc_q;
`ifdef DISPLAY_HEX_EN
    assign value_hex = hex_q;
`endif

endmodule

// File: rtl/display_scan_bcd.sv
// Multiplexed common-anode seven-segment driver: BCD conversion, blanking, overflow dash, scan.
// Optional DISPLAY_HEX_EN adds a Hex input that shows N's raw nibbles with A-F glyphs.
module display_scan_bcd
    import display_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [DATA_W-1:0] N,
`ifdef DISPLAY_HEX_EN
    input  logic              Hex,
`endif
    output logic [7:0]        Displays,
    output logic [7:0]        Segmentos,
    output logic              Busy
);

    localparam int NIBBLES = bcd_nibbles(DATA_W);
    localparam int BCD_W   = 4 * NIBBLES;
    localparam int EXT_N   = (NIBBLES > DIGITS) ? NIBBLES : DIGITS;
    localparam int CNT_W   = $clog2(REFRESH_DIV);

    logic [DATA_W-1:0]   shown_q;
    logic [DATA_W-1:0]   conv_value;
    logic [BCD_W-1:0]    bcd;
    logic [4*EXT_N-1:0]  bcd_ext;
    logic                start;
    logic                done;
    logic [4*DIGITS-1:0] digits_q;
    logic                ovf_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          idx_q;
    logic [7:0]          seg_code [DIGITS];
    logic [7:0]          seg_sel;
    logic [3:0]          nib;
    int unsigned         msd;
`ifdef DISPLAY_HEX_EN
    logic                shown_hex_q;
    logic                conv_hex;

    assign start = (N != shown_q) || (Hex != shown_hex_q);
`else
    assign start = (N != shown_q);
`endif

    bin2bcd_seq #(
        .DATA_W  (DATA_W),
        .NIBBLES (NIBBLES)
    ) u_conv (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .start     (start),
`ifdef DISPLAY_HEX_EN
        .hex       (Hex),
        .value_hex (conv_hex),
`endif
        .bin       (N),
        .busy      (Busy),
        .done      (done),
        .value     (conv_value),
        .bcd       (bcd)
    );

    // Digit registers change only on done, so the display never shows a partial result
    assign bcd_ext = (4*EXT_N)'(bcd);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            shown_q  <= '0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
`ifdef DISPLAY_HEX_EN
            shown_hex_q <= 1'b0;
`endif
        end else if (done) begin
            shown_q  <= conv_value;
            digits_q <= bcd_ext[4*DIGITS-1:0];
            ovf_q    <= |(bcd_ext >> (4*DIGITS));
`ifdef DISPLAY_HEX_EN
            shown_hex_q <= conv_hex;
`endif
        end
    end

    always_comb begin
        msd = 0;
        nib = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (digits_q[4*i +: 4] != 4'd0) begin
                msd = i;
            end
        end
        for (int unsigned i = 0; i < DIGITS; i++) begin
            nib = digits_q[4*i +: 4];
            if (ovf_q) begin
                seg_code[i] = SEG_DASH;
            end else if (i > msd) begin
                seg_code[i] = SEG_BLANK;
`ifdef DISPLAY_HEX_EN
            end else begin
                seg_code[i] = GLYPH[nib];
            end
`else
            end else if (nib > 4'd9) begin
                seg_code[i] = SEG_BLANK;
            end else begin
                seg_code[i] = GLYPH[nib];
            end
`endif
        end
    end

    always_comb begin
        seg_sel = SEG_BLANK;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                seg_sel = seg_code[i];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            Displays  <= '1;
            Segmentos <= '1;
        end else if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_q     <= '0;
            Displays  <= ~(8'd1 << idx_q);
            Segmentos <= seg_sel;
            idx_q     <= (idx_q == 3'(DIGITS - 1)) ? '0 : idx_q + 3'd1;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_display_scan_bcd.sv
// Randomized self-checking bench: two instances (3 digits and 2 digits) share N and
// are compared against an arithmetic reference of the displayed digits.
module tb_display_scan_bcd;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic [7:0] N = 8'd0;
    logic [7:0] disp3, seg3, disp2, seg2;
    logic       busy3, busy2;
`ifdef DISPLAY_HEX_EN
    logic       Hex = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int prev_n   = 0;

    logic [7:0] gly [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h98};

    always #5 Clk = ~Clk;

    display_scan_bcd #(.DATA_W(8), .DIGITS(3), .REFRESH_DIV(4)) dut3 (
        .Clk(Clk), .Rst_n(Rst_n), .N(N),
`ifdef DISPLAY_HEX_EN
        .Hex(Hex),
`endif
        .Displays(disp3), .Segmentos(seg3), .Busy(busy3)
    );

    display_scan_bcd #(.DATA_W(8), .DIGITS(2), .REFRESH_DIV(4)) dut2 (
        .Clk(Clk), .Rst_n(Rst_n), .N(N),
`ifdef DISPLAY_HEX_EN
        .Hex(Hex),
`endif
        .Displays(disp2), .Segmentos(seg2), .Busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Segment code expected on digit i of a d-digit display showing v
    function automatic logic [7:0] exp_seg(input int v, input int d, input int i);
        int lim = 1;
        int p = 1;
        for (int k = 0; k < d; k++) lim *= 10;
        for (int k = 0; k < i; k++) p *= 10;
        if (v >= lim) return 8'hBF;
        if (i > 0 && v < p) return 8'hFF;
        return gly[(v / p) % 10];
    endfunction

    task automatic count_busy(input string tag, input int window, input int exp);
        int c3 = 0;
        int c2 = 0;
        repeat (window) begin
            @(negedge Clk);
            if (busy3) c3++;
            if (busy2) c2++;
        end
        chk({tag, " busy3"}, c3, exp);
        chk({tag, " busy2"}, c2, exp);
    endtask

    task automatic check_display(input string tag, input int v);
        logic [7:0] s3 [3];
        logic [7:0] s2 [2];
        logic [7:0] m;
        s3 = '{8'h00, 8'h00, 8'h00};
        s2 = '{8'h00, 8'h00};
        repeat (16) @(negedge Clk);
        repeat (24) begin
            @(negedge Clk);
            for (int i = 0; i < 3; i++) begin
                m = 8'd1 << i;
                m = ~m;
                if (disp3 == m) s3[i] = seg3;
                if (i < 2 && disp2 == m) s2[i] = seg2;
            end
        end
        for (int i = 0; i < 3; i++)
            chk($sformatf("%s v=%0d d3[%0d]", tag, v, i), s3[i], exp_seg(v, 3, i));
        for (int i = 0; i < 2; i++)
            chk($sformatf("%s v=%0d d2[%0d]", tag, v, i), s2[i], exp_seg(v, 2, i));
        chk({tag, " d2 upper anodes off"}, disp2[7:2], 6'h3F);
    endtask

    task automatic apply(input string tag, input int v);
        @(negedge Clk);
        N = 8'(v);
        count_busy(tag, 20, (v != prev_n) ? 9 : 0);
        prev_n = v;
        check_display(tag, v);
    endtask

    int dir [8] = '{125, 4, 0, 9, 10, 100, 99, 99};
    int v;

    initial begin
        repeat (3) @(negedge Clk);
        chk("reset disp", disp3, 8'hFF);
        chk("reset seg", seg3, 8'hFF);
        chk("reset busy", busy3, 1'b0);
        Rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge Clk);
            #1;
            if (k == 3) chk("scan k3 disp", disp3, 8'hFF);
            if (k == 4) begin
                chk("scan k4 disp", disp3, 8'hFE);
                chk("scan k4 seg", seg3, 8'hC0);
            end
            if (k == 8) begin
                chk("scan k8 disp", disp3, 8'hFD);
                chk("scan k8 seg", seg3, 8'hFF);
            end
            if (k == 12) begin
                chk("scan k12 disp", disp3, 8'hFB);
                chk("scan k12 seg", seg3, 8'hFF);
                chk("scan k12 disp2", disp2, 8'hFE);
            end
            if (k == 16) chk("scan k16 disp", disp3, 8'hFE);
            chk($sformatf("scan k%0d busy", k), busy3, 1'b0);
        end

        foreach (dir[i]) apply("dir", dir[i]);

        // N changes mid-conversion: current one finishes, then a second one follows
        @(negedge Clk);
        N = 8'd25;
        count_busy("midchg a", 4, 4);
        N = 8'd249;
        count_busy("midchg b", 24, 14);
        prev_n = 249;
        check_display("midchg", 249);

        // Reset during SHIFT aborts; a fresh conversion runs after release
        @(negedge Clk);
        N = 8'd200;
        repeat (3) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        chk("rst mid disp3", disp3, 8'hFF);
        chk("rst mid seg3", seg3, 8'hFF);
        chk("rst mid busy3", busy3, 1'b0);
        chk("rst mid disp2", disp2, 8'hFF);
        @(negedge Clk);
        Rst_n = 1'b1;
        count_busy("rst rel", 20, 9);
        prev_n = 200;
        check_display("rst rel", 200);

        for (int r = 0; r < 20; r++) begin
            v = int'($urandom_range(0, 255));
            apply("rnd", v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
